// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared encodings for the data-memory arbiter and the load/store unit.
// Contents:
//   SIZE_*    2-bit access-size encodings that also drive the memory MemWrite/MemRead strobes.
//   state_e   arbiter sequencer states.
//   PORT0/1   requester ids (0 = pipeline load/store unit, 1 = DMA/debug loader).
package data_mem_pkg;

  localparam logic [1:0] SIZE_NONE = 2'b00;
  localparam logic [1:0] SIZE_WORD = 2'b01;
  localparam logic [1:0] SIZE_HALF = 2'b10;
  localparam logic [1:0] SIZE_BYTE = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/data_mem_align_check.sv
// data_mem_align_check: combinational legality check for one memory access.
// Ports:
//   i_size  access size (SIZE_* encoding)
//   i_addr  byte address
//   o_err   1 when the size is invalid, the address is misaligned for the size,
//           or the address lies at or beyond MEM_BYTES
module data_mem_align_check
  import data_mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic [1:0]  i_size,
  input  logic [31:0] i_addr,
  output logic        o_err
);

  always_comb begin
    o_err = 1'b0;
    case (i_size)
      SIZE_NONE: o_err = 1'b1;
      SIZE_WORD: o_err = (i_addr[1:0] != 2'b00);
      SIZE_HALF: o_err = i_addr[0];
      default:   o_err = 1'b0;
    endcase
    if (i_addr >= 32'(MEM_BYTES)) begin
      o_err = 1'b1;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: two-port arbiter/sequencer in front of the single-ported data memory.
// Each granted access spends one ACCESS cycle (Gnt + memory strobes) and one RESP cycle
// (Done/Err/RData). Port 0 wins by default; port 1 is forced through after MAX_WAIT
// consecutive lost arbitrations.
// Ports:
//   Clk, Rst_n                 clock, asynchronous active-low reset
//   Req/We/Size/Addr/WData 0,1 request fields, held stable until the matching Gnt
//   Gnt0/Gnt1                  one-cycle grant pulse (ACCESS)
//   Done0/Done1, Err0/Err1     one-cycle response pulse and reject flag (RESP)
//   RData0/RData1              load data, updated only by error-free loads
//   MemAddress/MemWriteData    memory address / store data (hold outside ACCESS)
//   MemWrite/MemRead           memory size strobes, non-zero only in ACCESS
//   MemReadData                memory read data, sampled at the edge ending ACCESS
module data_mem_arbiter
  import data_mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 4096,
  parameter int unsigned MAX_WAIT  = 4
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Req0,
  input  logic        Req1,
  input  logic        We0,
  input  logic        We1,
  input  logic [1:0]  Size0,
  input  logic [1:0]  Size1,
  input  logic [31:0] Addr0,
  input  logic [31:0] Addr1,
  input  logic [31:0] WData0,
  input  logic [31:0] WData1,
  output logic        Gnt0,
  output logic        Gnt1,
  output logic        Done0,
  output logic        Done1,
  output logic        Err0,
  output logic        Err1,
  output logic [31:0] RData0,
  output logic [31:0] RData1,
  output logic [31:0] MemAddress,
  output logic [31:0] MemWriteData,
  output logic [1:0]  MemWrite,
  output logic [1:0]  MemRead,
  input  logic [31:0] MemReadData
);

  localparam int unsigned WaitW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  state_e             r_state, w_state_next;
  logic [WaitW-1:0]   r_wait1, w_wait1_next;
  logic               r_id;
  logic               r_we;
  logic               r_err;
  logic [1:0]         r_size;
  logic [31:0]        r_addr;
  logic [31:0]        r_wdata;
  logic [31:0]        r_rdata0;
  logic [31:0]        r_rdata1;

  logic               w_arb;
  logic               w_win1;
  logic               w_win_we;
  logic [1:0]         w_win_size;
  logic [31:0]        w_win_addr;
  logic [31:0]        w_win_wdata;
  logic               w_win_err;

  // Arbitration happens in IDLE and RESP; ACCESS is the single busy cycle.
  always_comb begin
    w_arb       = (r_state != ACCESS) && (Req0 || Req1);
    w_win1      = Req1 && (!Req0 || (r_wait1 == WaitW'(MAX_WAIT)));
    w_win_we    = w_win1 ? We1    : We0;
    w_win_size  = w_win1 ? Size1  : Size0;
    w_win_addr  = w_win1 ? Addr1  : Addr0;
    w_win_wdata = w_win1 ? WData1 : WData0;
  end

  data_mem_align_check #(
    .MEM_BYTES (MEM_BYTES)
  ) u_align_check (
    .i_size (w_win_size),
    .i_addr (w_win_addr),
    .o_err  (w_win_err)
  );

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE, RESP: w_state_next = (Req0 || Req1) ? ACCESS : IDLE;
      ACCESS:     w_state_next = RESP;
      default:    w_state_next = IDLE;
    endcase
  end

  // Wait1 counts lost arbitrations of a pending port-1 request; it holds through
  // ACCESS and saturates at MAX_WAIT.
  always_comb begin
    w_wait1_next = r_wait1;
    if (!Req1) begin
      w_wait1_next = '0;
    end else if (w_arb) begin
      if (w_win1) begin
        w_wait1_next = '0;
      end else if (r_wait1 != WaitW'(MAX_WAIT)) begin
        w_wait1_next = r_wait1 + WaitW'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state  <= IDLE;
      r_wait1  <= '0;
      r_id     <= PORT0;
      r_we     <= 1'b0;
      r_err    <= 1'b0;
      r_size   <= SIZE_NONE;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_state <= w_state_next;
      r_wait1 <= w_wait1_next;
      if (w_arb) begin
        r_id    <= w_win1 ? PORT1 : PORT0;
        r_we    <= w_win_we;
        r_size  <= w_win_size;
        r_addr  <= w_win_addr;
        r_wdata <= w_win_wdata;
        r_err   <= w_win_err;
      end
      // Memory read data settles at the ACCESS negedge; capture it at the edge ending ACCESS.
      if ((r_state == ACCESS) && !r_err && !r_we) begin
        if (r_id == PORT1) begin
          r_rdata1 <= MemReadData;
        end else begin
          r_rdata0 <= MemReadData;
        end
      end
    end
  end

  always_comb begin
    MemWrite = SIZE_NONE;
    MemRead  = SIZE_NONE;
    if ((r_state == ACCESS) && !r_err) begin
      if (r_we) begin
        MemWrite = r_size;
      end else begin
        MemRead = r_size;
      end
    end
  end

  // The latched fields only change on a grant, so they double as the held memory bus.
  assign MemAddress   = r_addr;
  assign MemWriteData = r_wdata;

  assign Gnt0  = (r_state == ACCESS) && (r_id == PORT0);
  assign Gnt1  = (r_state == ACCESS) && (r_id == PORT1);
  assign Done0 = (r_state == RESP) && (r_id == PORT0);
  assign Done1 = (r_state == RESP) && (r_id == PORT1);
  assign Err0  = Done0 && r_err;
  assign Err1  = Done1 && r_err;

  assign RData0 = r_rdata0;
  assign RData1 = r_rdata1;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Testbench for data_mem_arbiter: scoreboard with a transaction-level reference model,
// a behavioural data memory, directed scenarios and randomized two-port traffic.
module tb_data_mem_arbiter;
  import data_mem_pkg::*;

  localparam int unsigned MEM_BYTES = 4096;
  localparam int unsigned MAX_WAIT  = 4;

  logic        Clk;
  logic        Rst_n;
  logic        Req0, Req1, We0, We1;
  logic [1:0]  Size0, Size1;
  logic [31:0] Addr0, Addr1, WData0, WData1;
  logic        Gnt0, Gnt1, Done0, Done1, Err0, Err1;
  logic [31:0] RData0, RData1;
  logic [31:0] MemAddress, MemWriteData, MemReadData;
  logic [1:0]  MemWrite, MemRead;

  data_mem_arbiter #(
    .MEM_BYTES (MEM_BYTES),
    .MAX_WAIT  (MAX_WAIT)
  ) dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .Req0         (Req0),
    .Req1         (Req1),
    .We0          (We0),
    .We1          (We1),
    .Size0        (Size0),
    .Size1        (Size1),
    .Addr0        (Addr0),
    .Addr1        (Addr1),
    .WData0       (WData0),
    .WData1       (WData1),
    .Gnt0         (Gnt0),
    .Gnt1         (Gnt1),
    .Done0        (Done0),
    .Done1        (Done1),
    .Err0         (Err0),
    .Err1         (Err1),
    .RData0       (RData0),
    .RData1       (RData1),
    .MemAddress   (MemAddress),
    .MemWriteData (MemWriteData),
    .MemWrite     (MemWrite),
    .MemRead      (MemRead),
    .MemReadData  (MemReadData)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Little-endian lane helpers; the memory sign-extends sub-word loads.
  function automatic logic [31:0] lane_read(input logic [31:0] w, input logic [1:0] size,
                                            input logic [1:0] off);
    logic [31:0] s;
    s = w >> (8 * int'(off));
    case (size)
      SIZE_BYTE: return {{24{s[7]}}, s[7:0]};
      SIZE_HALF: return {{16{s[15]}}, s[15:0]};
      default:   return w;
    endcase
  endfunction

  function automatic logic [31:0] lane_write(input logic [31:0] w, input logic [1:0] size,
                                             input logic [1:0] off, input logic [31:0] d);
    logic [31:0] m;
    int sh;
    sh = 8 * int'(off);
    case (size)
      SIZE_BYTE: m = 32'h0000_00FF;
      SIZE_HALF: m = 32'h0000_FFFF;
      default:   m = 32'hFFFF_FFFF;
    endcase
    return (w & ~(m << sh)) | ((d & m) << sh);
  endfunction

  function automatic bit exp_err(input logic [1:0] size, input logic [31:0] addr);
    if (size == SIZE_NONE) return 1'b1;
    if (addr >= MEM_BYTES) return 1'b1;
    if (size == SIZE_WORD && (addr % 4) != 0) return 1'b1;
    if (size == SIZE_HALF && (addr % 2) != 0) return 1'b1;
    return 1'b0;
  endfunction

  // Behavioural data memory: reads on negedge, writes on posedge.
  bit [31:0] env_mem [1024];
  always @(posedge Clk) begin
    if (MemWrite != 2'b00) begin
      env_mem[MemAddress[11:2]] <= lane_write(env_mem[MemAddress[11:2]], MemWrite,
                                              MemAddress[1:0], MemWriteData);
    end
  end
  always @(negedge Clk) begin
    MemReadData <= (MemRead != 2'b00) ?
                   lane_read(env_mem[MemAddress[11:2]], MemRead, MemAddress[1:0]) : $urandom;
  end

  // Reference model and scoreboard queues.
  typedef struct {
    int          cyc;
    bit          port;
    logic [1:0]  mw;
    logic [1:0]  mr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } gnt_t;

  typedef struct {
    int          cyc;
    bit          port;
    bit          err;
    logic [31:0] rdata;
  } rsp_t;

  gnt_t gq[$];
  rsp_t rq[$];

  bit [31:0]   ref_mem [1024];
  int          cyc = 0;
  bit          m_can_arb = 1'b1;
  int          m_wait = 0;
  logic [31:0] m_rdata [2];
  bit          m_w1, m_we, m_err;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata;
  gnt_t        m_g;
  rsp_t        m_r;

  // Rules: one access per arbitration, the cycle after a grant is busy; port 0 wins unless
  // port 1 has already lost MAX_WAIT arbitrations in a row while requesting.
  initial begin
    m_rdata[0] = '0;
    m_rdata[1] = '0;
    forever begin
      @(posedge Clk or negedge Rst_n);
      if (!Rst_n) begin
        gq.delete();
        rq.delete();
        m_can_arb  = 1'b1;
        m_wait     = 0;
        m_rdata[0] = '0;
        m_rdata[1] = '0;
      end else begin
        cyc++;
        if (m_can_arb && (Req0 || Req1)) begin
          m_w1 = Req1 && (!Req0 || m_wait >= MAX_WAIT);
          if (Req1 && !m_w1) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : m_wait;
          else m_wait = 0;
          m_we    = m_w1 ? We1 : We0;
          m_size  = m_w1 ? Size1 : Size0;
          m_addr  = m_w1 ? Addr1 : Addr0;
          m_wdata = m_w1 ? WData1 : WData0;
          m_err   = exp_err(m_size, m_addr);
          m_g.cyc   = cyc;
          m_g.port  = m_w1;
          m_g.addr  = m_addr;
          m_g.wdata = m_wdata;
          m_g.mw    = (!m_err && m_we)  ? m_size : 2'b00;
          m_g.mr    = (!m_err && !m_we) ? m_size : 2'b00;
          if (!m_err && m_we)
            ref_mem[m_addr[11:2]] = lane_write(ref_mem[m_addr[11:2]], m_size, m_addr[1:0],
                                               m_wdata);
          if (!m_err && !m_we)
            m_rdata[m_w1] = lane_read(ref_mem[m_addr[11:2]], m_size, m_addr[1:0]);
          m_r.cyc   = cyc + 1;
          m_r.port  = m_w1;
          m_r.err   = m_err;
          m_r.rdata = m_rdata[m_w1];
          gq.push_back(m_g);
          rq.push_back(m_r);
          m_can_arb = 1'b0;
        end else begin
          if (!Req1) m_wait = 0;
          m_can_arb = 1'b1;
        end
      end
    end
  end

  // Monitor: compares whenever the DUT presents a grant or a response.
  gnt_t mon_g;
  rsp_t mon_r;
  initial begin
    forever begin
      @(negedge Clk);
      if (Rst_n) begin
        if (Gnt0 || Gnt1) begin
          if (gq.size() == 0) begin
            check("unexpected_gnt", {Gnt1, Gnt0}, 2'b00);
          end else begin
            mon_g = gq.pop_front();
            check("gnt_cycle", cyc, mon_g.cyc);
            check("gnt_port", {Gnt1, Gnt0}, mon_g.port ? 2'b10 : 2'b01);
            check("mem_strobe", {MemWrite, MemRead}, {mon_g.mw, mon_g.mr});
            check("mem_addr", MemAddress, mon_g.addr);
            check("mem_wdata", MemWriteData, mon_g.wdata);
          end
        end else begin
          check("idle_strobe", {MemWrite, MemRead}, 4'b0000);
          if (gq.size() != 0 && gq[0].cyc <= cyc) begin
            mon_g = gq.pop_front();
            check("missing_gnt", {Gnt1, Gnt0}, mon_g.port ? 2'b10 : 2'b01);
          end
        end
        if (Done0 || Done1) begin
          if (rq.size() == 0) begin
            check("unexpected_done", {Done1, Done0}, 2'b00);
          end else begin
            mon_r = rq.pop_front();
            check("done_cycle", cyc, mon_r.cyc);
            check("done_port", {Done1, Done0}, mon_r.port ? 2'b10 : 2'b01);
            check("err", mon_r.port ? Err1 : Err0, mon_r.err);
            check("rdata", mon_r.port ? RData1 : RData0, mon_r.rdata);
          end
        end else if (rq.size() != 0 && rq[0].cyc <= cyc) begin
          mon_r = rq.pop_front();
          check("missing_done", {Done1, Done0}, mon_r.port ? 2'b10 : 2'b01);
        end
      end
    end
  end

  // Stimulus helpers; callers are aligned at posedge + 1.
  task automatic drive(input bit p, input logic r, input logic we, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (p) begin
      Req1 = r; We1 = we; Size1 = size; Addr1 = addr; WData1 = wdata;
    end else begin
      Req0 = r; We0 = we; Size0 = size; Addr0 = addr; WData0 = wdata;
    end
  endtask

  task automatic issue(input bit p, input logic we, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata, input bit keep);
    bit ok;
    ok = 1'b0;
    drive(p, 1'b1, we, size, addr, wdata);
    for (int i = 0; i < 64; i++) begin
      @(negedge Clk);
      if ((p ? Gnt1 : Gnt0) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("gnt_timeout", p ? Gnt1 : Gnt0, 1'b1);
    @(posedge Clk);
    #1;
    if (!keep) drive(p, 1'b0, 1'b0, SIZE_NONE, '0, '0);
  endtask

  task automatic rand_port(input bit p, input int n);
    logic       we;
    logic [1:0] size;
    logic [31:0] addr;
    int kind;
    bit keep;
    for (int i = 0; i < n; i++) begin
      we   = 1'($urandom_range(0, 1));
      size = ($urandom_range(0, 7) == 0) ? SIZE_NONE : 2'($urandom_range(1, 3));
      kind = $urandom_range(0, 9);
      addr = 32'($urandom_range(0, 63));
      if (kind == 9) addr = 32'(MEM_BYTES - 4) + {30'b0, addr[1:0]};
      if (kind >= 2) begin
        if (size == SIZE_WORD) addr[1:0] = 2'b00;
        if (size == SIZE_HALF) addr[0] = 1'b0;
      end
      if (kind == 0) addr = 32'(MEM_BYTES) + {addr[31:2], 2'b00};
      keep = (i < n - 1) && ($urandom_range(0, 1) == 1);
      issue(p, we, size, addr, $urandom, keep);
      if (!keep) begin
        repeat ($urandom_range(0, 3)) begin
          @(posedge Clk);
          #1;
        end
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, {Gnt1, Gnt0}, 2'b00);
    check({tag, "_done_err"}, {Done1, Done0, Err1, Err0}, 4'b0000);
    check({tag, "_rdata"}, {RData1, RData0}, 64'h0);
    check({tag, "_strobe"}, {MemWrite, MemRead}, 4'b0000);
    check({tag, "_bus"}, {MemAddress, MemWriteData}, 64'h0);
  endtask

  int g0cnt;
  int p1_at;

  initial begin
    Rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, SIZE_NONE, '0, '0);
    drive(1'b1, 1'b0, 1'b0, SIZE_NONE, '0, '0);
    repeat (3) @(posedge Clk);
    #1;
    check_all_zero("reset");
    @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;

    // Directed accesses.
    issue(1'b0, 1'b1, SIZE_WORD, 32'h10, 32'hDEAD_BEEF, 1'b0);
    issue(1'b0, 1'b0, SIZE_WORD, 32'h10, 32'h0, 1'b0);
    issue(1'b1, 1'b1, SIZE_BYTE, 32'h13, 32'h0000_00A5, 1'b0);
    issue(1'b1, 1'b0, SIZE_BYTE, 32'h13, 32'h0, 1'b0);
    issue(1'b0, 1'b0, SIZE_WORD, 32'h6, 32'h0, 1'b0);
    issue(1'b1, 1'b0, SIZE_HALF, 32'h1002, 32'h0, 1'b0);
    issue(1'b0, 1'b1, SIZE_NONE, 32'h20, 32'h1234_5678, 1'b0);
    issue(1'b1, 1'b1, SIZE_HALF, 32'hFFE, 32'h0000_8001, 1'b0);
    issue(1'b0, 1'b0, SIZE_HALF, 32'hFFE, 32'h0, 1'b0);
    repeat (3) begin @(posedge Clk); #1; end

    // Port 0 requests back to back while port 1 waits.
    g0cnt = 0;
    p1_at = -1;
    fork
      begin
        for (int i = 0; i < 7; i++) begin
          issue(1'b0, 1'b0, SIZE_WORD, 32'(4 * i), 32'h0, i < 6);
          g0cnt++;
        end
      end
      begin
        issue(1'b1, 1'b0, SIZE_WORD, 32'h40, 32'h0, 1'b0);
        p1_at = g0cnt;
      end
    join
    check("starve_p0_grants_before_p1", p1_at, MAX_WAIT);
    repeat (3) begin @(posedge Clk); #1; end

    // Reset asserted in the middle of an ACCESS cycle.
    drive(1'b0, 1'b1, 1'b0, SIZE_WORD, 32'h10, '0);
    for (int i = 0; i < 16; i++) begin
      @(negedge Clk);
      if (Gnt0) break;
    end
    check("pre_reset_gnt", Gnt0, 1'b1);
    #1;
    Rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, SIZE_NONE, '0, '0);
    #1;
    check_all_zero("midreset");
    @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;
    issue(1'b0, 1'b0, SIZE_WORD, 32'h10, 32'h0, 1'b0);
    repeat (3) begin @(posedge Clk); #1; end

    // Randomized concurrent traffic.
    fork
      rand_port(1'b0, 40);
      rand_port(1'b1, 40);
    join
    repeat (6) begin @(posedge Clk); #1; end
    check("gq_drained", gq.size(), 0);
    check("rq_drained", rq.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at t=%0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter and sequencer in front of the single-ported data memory. It shares the memory between the pipeline load/store unit (port 0) and the DMA/debug loader (port 1). For each granted access it drives the memory's 2-bit MemWrite/MemRead size encodings for exactly one cycle and returns a registered response. Misaligned and out-of-range requests are rejected before they reach memory.

## Interface
Parameters:
- MEM_BYTES, 4096: addressable bytes; any higher address bit set is an error.
- MAX_WAIT, 4: consecutive lost arbitrations after which port 1 is forced to win.

Ports:
- Clk  in  1  single clock; memory writes on posedge and reads on negedge.
- Rst_n  in  1  reset, asynchronous, active-low.
- Req0/Req1  in  1  request; held with its fields stable until the matching Gnt.
- We0/We1  in  1  1 = store, 0 = load.
- Size0/Size1  in  2  01 word, 10 half, 11 byte, 00 invalid.
- Addr0/Addr1  in  32  byte address.
- WData0/WData1  in  32  store data, right-aligned for half/byte.
- Gnt0/Gnt1  out  1  one-cycle grant pulse.
- Done0/Done1  out  1  one-cycle response pulse.
- Err0/Err1  out  1  valid with Done; access rejected.
- RData0/RData1  out  32  load result, valid with Done when not Err.
- MemAddress  out  32  to memory Address.
- MemWriteData  out  32  to memory WriteData.
- MemWrite  out  2  to memory MemWrite.
- MemRead  out  2  to memory MemRead.
- MemReadData  in  32  from memory ReadData.

## Operation
- FSM states: IDLE, ACCESS, RESP.
  - IDLE, no request: stay in IDLE.
  - IDLE, any request: latch the winner's We, Size, Addr and WData plus the winner id; compute the error flag; go to ACCESS.
  - ACCESS: always go to RESP.
  - RESP: arbitrate exactly as IDLE. With a request present go straight to ACCESS, otherwise go to IDLE.
- Arbitration: port 0 wins by default.
  - Wait1 counts cycles in which Req1 is high and port 1 loses an arbitration.
  - When Wait1 == MAX_WAIT, port 1 wins the next arbitration.
  - Wait1 clears when port 1 is granted or when Req1 is low.
  - Wait1 saturates and never wraps.
- Error flag is set when any of these holds:
  - Size == 00;
  - word access with Addr[1:0] != 00;
  - half access with Addr[0] == 1;
  - Addr >= MEM_BYTES.
- ACCESS cycle:
  - Gnt of the winner is high.
  - MemAddress = latched Addr; MemWriteData = latched WData.
  - If no error: MemWrite = Size when We = 1, else MemRead = Size.
  - If error: MemWrite and MemRead stay 00.
- Outside ACCESS: MemWrite = MemRead = 00; MemAddress and MemWriteData hold their last values.
- RESP cycle:
  - Done of the winner is high; Err of the winner = error flag.
  - For an error-free load, RData of the winner = MemReadData sampled at the posedge that ends ACCESS.
  - RData holds its previous value for stores and errors.
- Sign extension is performed by memory; the arbiter passes RData through unchanged.

## Timing
- Request sampled at edge N (state IDLE/RESP).
- Gnt and memory strobes are high in cycle N+1 (ACCESS). Memory read data settles at the negedge of N+1; a write commits at edge N+2.
- Done/Err/RData are valid in cycle N+2.
- Back-to-back throughput is one access per 2 cycles: alternating ACCESS/RESP.
- A requester sees Gnt during ACCESS and must drop or change Req by the next edge, so RESP never re-grants the same transaction.
- Simultaneous Req0/Req1 with Wait1 < MAX_WAIT: port 0 wins and Wait1 increments.
- Rst_n low in any state forces immediately:
  - state IDLE, Wait1 = 0;
  - all Gnt/Done/Err = 0, RData = 0;
  - MemWrite = MemRead = 00, MemAddress = MemWriteData = 0.
- A reset during ACCESS may abort a store; that is acceptable.

## Structure
- Package data_mem_pkg:
  - size encodings SIZE_NONE, SIZE_WORD, SIZE_HALF, SIZE_BYTE;
  - state typedef with IDLE, ACCESS, RESP;
  - port-id constants.
- Sub-module data_mem_align_check: combinational (Size, Addr) -> error. It is reused later by the load/store unit.

## Test plan
- Reset, then a port 0 word store of 0xDEADBEEF at 0x10, then a word load at 0x10: store shows MemWrite = 01 in exactly one cycle; load gives Done0 two cycles after sampling with RData0 = 0xDEADBEEF and Err0 = 0.
- Port 1 byte store of 0xA5 at 0x13, then port 1 byte load at 0x13: MemWrite = 11 with MemAddress = 0x13; load gives RData1 = 0xFFFFFFA5.
- Req0 held continuously with Req1 high, MAX_WAIT = 4: port 1 is granted on the 5th arbitration, then port 0 resumes.
- Port 0 word load at 0x6: Gnt0 then Done0 + Err0; MemRead stays 00 throughout.
- Half load at 0x1002 and any Size = 00 request: Err asserted, no memory strobe.
- Rst_n pulled low mid-ACCESS: all outputs 0 asynchronously; the next request after release completes normally in 2 cycles.
